// File: rtl/data_memory_adapter_pkg.sv
// Shared constants and types for the data memory adapter.
// Holds funct3 encodings, FSM states and byte-enable patterns.
package data_memory_adapter_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESPOND
  } state_t;

  function automatic logic opt_undefined(input logic [2:0] opt);
    return (opt == 3'b011) || (opt == 3'b110) || (opt == 3'b111);
  endfunction

endpackage

// File: rtl/data_memory_adapter_aligner.sv
// Combinational lane logic for sub-word stores and loads.
// Store side builds strobes/lanes, load side selects and extends.
module load_store_aligner
  import data_memory_adapter_pkg::*;
(
  input  logic [2:0]  i_option,
  input  logic [1:0]  i_byte_off,
  input  logic [31:0] i_store_data,
  input  logic [31:0] i_load_data,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_load_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Store lanes: replicate the datum, strobe only its lanes
  always_comb begin
    o_be    = BE_WORD;
    o_wdata = i_store_data;
    case (i_option[1:0])
      2'b00: begin
        o_be    = BE_BYTE << i_byte_off;
        o_wdata = {4{i_store_data[7:0]}};
      end
      2'b01: begin
        o_be    = BE_HALF << i_byte_off;
        o_wdata = {2{i_store_data[15:0]}};
      end
      default: begin
        o_be    = BE_WORD;
        o_wdata = i_store_data;
      end
    endcase
  end

  // Load lanes: pick byte/halfword, then sign or zero extend
  always_comb begin
    w_byte = i_load_data[7:0];
    case (i_byte_off)
      2'd0:    w_byte = i_load_data[7:0];
      2'd1:    w_byte = i_load_data[15:8];
      2'd2:    w_byte = i_load_data[23:16];
      default: w_byte = i_load_data[31:24];
    endcase
    w_half = i_byte_off[1] ? i_load_data[31:16] : i_load_data[15:0];
    case (i_option)
      F3_B:    o_load_data = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_load_data = {24'h0, w_byte};
      F3_H:    o_load_data = {{16{w_half[15]}}, w_half};
      F3_HU:   o_load_data = {16'h0, w_half};
      default: o_load_data = i_load_data;
    endcase
  end

endmodule

// File: rtl/data_memory_adapter.sv
// Core memory bus to word-addressed byte-enable RAM adapter.
// One RAM access per request, single-cycle completion pulse.
module data_memory_adapter
  import data_memory_adapter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 12,
  parameter logic [31:0] BASE_ADDRESS = 32'h00000000,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_read,
  input  logic                  req_write,
  input  logic [2:0]            req_option,
  input  logic [31:0]           req_address,
  input  logic [31:0]           req_write_data,
  output logic                  rsp_valid,
  output logic                  rsp_error,
  output logic [31:0]           rsp_read_data,
  output logic                  mem_en,
  output logic [3:0]            mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata
);

  localparam logic [2:0] LP_LAT = 3'(READ_LATENCY);

  state_t                r_state;
  logic [2:0]            r_option;
  logic [1:0]            r_byte_off;
  logic                  r_is_write;
  logic [2:0]            r_cnt;
  logic                  r_rsp_valid;
  logic                  r_rsp_error;
  logic [31:0]           r_rsp_data;
  logic                  r_mem_en;
  logic [3:0]            r_mem_we;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [31:0]           r_mem_wdata;

  logic [31:0] w_offset;
  logic        w_misaligned;
  logic        w_range_err;
  logic        w_err;
  logic [2:0]  w_al_opt;
  logic [1:0]  w_al_off;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_load;

  // BASE_ADDRESS is expected word aligned, so offset low bits are the lane
  assign w_offset    = req_address - BASE_ADDRESS;
  assign w_range_err = |w_offset[31:ADDR_WIDTH+2];

  // Alignment check by access size
  always_comb begin
    w_misaligned = 1'b0;
    case (req_option[1:0])
      2'b01:   w_misaligned = w_offset[0];
      2'b10:   w_misaligned = |w_offset[1:0];
      default: w_misaligned = 1'b0;
    endcase
  end

  assign w_err = w_misaligned | w_range_err
               | (req_read & req_write)
               | opt_undefined(req_option);

  // Live request drives the aligner in IDLE, latched one afterwards
  assign w_al_opt = (r_state == S_IDLE) ? req_option : r_option;
  assign w_al_off = (r_state == S_IDLE) ? w_offset[1:0] : r_byte_off;

  load_store_aligner u_aligner (
    .i_option     (w_al_opt),
    .i_byte_off   (w_al_off),
    .i_store_data (req_write_data),
    .i_load_data  (mem_rdata),
    .o_be         (w_be),
    .o_wdata      (w_wdata),
    .o_load_data  (w_load)
  );

  // Request FSM with registered RAM strobes and response
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_option    <= '0;
      r_byte_off  <= '0;
      r_is_write  <= 1'b0;
      r_cnt       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_error <= 1'b0;
      r_rsp_data  <= '0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_read || req_write) begin
            r_option   <= req_option;
            r_byte_off <= w_offset[1:0];
            r_is_write <= req_write;
            if (w_err) begin
              r_rsp_valid <= 1'b1;
              r_rsp_error <= 1'b1;
              r_state     <= S_RESPOND;
            end else begin
              r_mem_en    <= 1'b1;
              r_mem_we    <= req_write ? w_be : 4'b0000;
              r_mem_addr  <= w_offset[ADDR_WIDTH+1:2];
              r_mem_wdata <= req_write ? w_wdata : 32'h0;
              r_state     <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          r_mem_en <= 1'b0;
          r_mem_we <= 4'b0000;
          if (r_is_write) begin
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESPOND;
          end else begin
            r_cnt   <= LP_LAT;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_cnt == 3'd1) begin
            r_rsp_data  <= w_load;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESPOND;
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
        default: begin
          r_rsp_valid <= 1'b0;
          r_rsp_error <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign rsp_valid     = r_rsp_valid;
  assign rsp_error     = r_rsp_error;
  assign rsp_read_data = r_rsp_data;
  assign mem_en        = r_mem_en;
  assign mem_we        = r_mem_we;
  assign mem_addr      = r_mem_addr;
  assign mem_wdata     = r_mem_wdata;

endmodule
